// File: rtl/keypad_emulator_pkg.sv
// Shared keypad definitions: key-code to {row,col} map and emulator FSM states.
// The scanner decode imports the same table so both ends agree on the layout.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MAKE  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_BREAK = 3'd3,
    ST_DONE  = 3'd4
  } kp_state_e;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_pos_t;

  // Indexed by hex key code; entry is {row,col}, row/col 0 = top/left.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'b1101, 4'b0000, 4'b0001, 4'b0010,   // 0 1 2 3
    4'b0100, 4'b0101, 4'b0110, 4'b1000,   // 4 5 6 7
    4'b1001, 4'b1010, 4'b0011, 4'b0111,   // 8 9 A B
    4'b1011, 4'b1111, 4'b1100, 4'b1110    // C D E F
  };

  function automatic key_pos_t key_pos(input logic [3:0] code);
    key_pos_t p;
    p = key_pos_t'(KEY_MAP[code]);
    return p;
  endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Scanner-facing bus of the keypad emulator: press command, column drive and row response.
interface keypad_emulator_if #(
  parameter int HOLD_W = 24
) ();

  logic              start;
  logic [3:0]        key;
  logic [HOLD_W-1:0] hold_cycles;
  logic              bounce_en;
  logic [3:0]        cols;
  logic [3:0]        rows;
  logic              busy;
  logic              done;

  modport master (
    output start, key, hold_cycles, bounce_en, cols,
    input  rows, busy, done
  );

  modport slave (
    input  start, key, hold_cycles, bounce_en, cols,
    output rows, busy, done
  );

endinterface

// File: rtl/keypad_emulator_bounce_gen.sv
// Contact bounce burst generator: starts at init_level, toggles every PERIOD cycles,
// and flags done on the cycle whose edge applies the final toggle.
module keypad_emulator_bounce_gen #(
  parameter int PERIOD  = 600,
  parameter int TOGGLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic init_level,
  output logic level,
  output logic done
);

  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int TW = (TOGGLES > 1) ? $clog2(TOGGLES) : 1;
  localparam logic [PW-1:0] PER_LAST = PW'(PERIOD - 1);
  localparam logic [TW-1:0] TOG_LAST = TW'(TOGGLES - 1);

  logic          active_r;
  logic          level_r;
  logic [PW-1:0] per_cnt_r;
  logic [TW-1:0] tog_cnt_r;
  logic          per_end_s;
  logic          last_s;

  assign per_end_s = active_r && (per_cnt_r == PER_LAST);
  assign last_s    = per_end_s && (tog_cnt_r == TOG_LAST);
  assign level     = level_r;
  assign done      = last_s;

  // Period and toggle counters plus the bouncing contact level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r  <= 1'b0;
      level_r   <= 1'b0;
      per_cnt_r <= {PW{1'b0}};
      tog_cnt_r <= {TW{1'b0}};
    end else if (start) begin
      active_r  <= 1'b1;
      level_r   <= init_level;
      per_cnt_r <= {PW{1'b0}};
      tog_cnt_r <= {TW{1'b0}};
    end else if (per_end_s) begin
      level_r   <= ~level_r;
      per_cnt_r <= {PW{1'b0}};
      if (last_s) begin
        active_r  <= 1'b0;
        tog_cnt_r <= {TW{1'b0}};
      end else begin
        tog_cnt_r <= tog_cnt_r + TW'(1);
      end
    end else if (active_r) begin
      per_cnt_r <= per_cnt_r + PW'(1);
    end else begin
      per_cnt_r <= {PW{1'b0}};
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad emulator: one commanded key press with optional make/break bounce.
// Rows respond combinationally to Cols, as a passive switch matrix would.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int BOUNCE_PERIOD  = 600,
  parameter int BOUNCE_TOGGLES = 8,
  parameter int HOLD_W         = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  keypad_emulator_if.slave  bus
);

  kp_state_e         state_r, next_s;
  logic [1:0]        key_row_r, key_col_r;
  logic              bounce_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic              busy_r, done_r;
  logic              cap_s, bg_start_s, bg_init_s;
  logic              bg_level_s, bg_done_s;
  logic              contact_s;
  logic [3:0]        rows_s;
  key_pos_t          pos_s;

  assign pos_s = key_pos(bus.key);

  keypad_emulator_bounce_gen #(
    .PERIOD  (BOUNCE_PERIOD),
    .TOGGLES (BOUNCE_TOGGLES)
  ) u_bounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (bg_start_s),
    .init_level (bg_init_s),
    .level      (bg_level_s),
    .done       (bg_done_s)
  );

  // Next-state decode; bounce bursts are launched on entry to MAKE and BREAK.
  always_comb begin
    next_s     = state_r;
    cap_s      = 1'b0;
    bg_start_s = 1'b0;
    bg_init_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          cap_s = 1'b1;
          if (bus.bounce_en) begin
            next_s     = ST_MAKE;
            bg_start_s = 1'b1;
            bg_init_s  = 1'b1;
          end else begin
            next_s = ST_HOLD;
          end
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_MAKE: begin
        if (bg_done_s) next_s = ST_HOLD;
        else           next_s = ST_MAKE;
      end
      ST_HOLD: begin
        if (hold_cnt_r == {HOLD_W{1'b0}}) begin
          if (bounce_r) begin
            next_s     = ST_BREAK;
            bg_start_s = 1'b1;
            bg_init_s  = 1'b0;
          end else begin
            next_s = ST_DONE;
          end
        end else begin
          next_s = ST_HOLD;
        end
      end
      ST_BREAK: begin
        if (bg_done_s) next_s = ST_DONE;
        else           next_s = ST_BREAK;
      end
      ST_DONE: next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  // State, captured command and hold countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      key_row_r  <= 2'd0;
      key_col_r  <= 2'd0;
      bounce_r   <= 1'b0;
      hold_cnt_r <= {HOLD_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r <= next_s;
      busy_r  <= (next_s != ST_IDLE);
      done_r  <= (next_s == ST_DONE);
      if (cap_s) begin
        key_row_r  <= pos_s.row;
        key_col_r  <= pos_s.col;
        bounce_r   <= bus.bounce_en;
        hold_cnt_r <= (bus.hold_cycles == {HOLD_W{1'b0}}) ? {HOLD_W{1'b0}}
                                                          : bus.hold_cycles - HOLD_W'(1);
      end else if ((state_r == ST_HOLD) && (hold_cnt_r != {HOLD_W{1'b0}})) begin
        hold_cnt_r <= hold_cnt_r - HOLD_W'(1);
      end else begin
        hold_cnt_r <= hold_cnt_r;
      end
    end
  end

  // Contact closure from registered state and bounce level only.
  always_comb begin
    case (state_r)
      ST_HOLD:           contact_s = 1'b1;
      ST_MAKE, ST_BREAK: contact_s = bg_level_s;
      default:           contact_s = 1'b0;
    endcase
  end

  // Switch matrix: the key's row follows its column only while closed.
  always_comb begin
    rows_s = 4'b1111;
    if (contact_s && !bus.cols[key_col_r]) begin
      rows_s[key_row_r] = 1'b0;
    end else begin
      rows_s = 4'b1111;
    end
  end

  assign bus.rows = rows_s;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_keypad_emulator.sv
// Randomized self-checking bench for keypad_emulator against a timeline-based key-press model.
module tb_keypad_emulator;

  localparam int HOLD_W = 24;
  localparam int BP     = 4;
  localparam int BT     = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  keypad_emulator_if #(.HOLD_W(HOLD_W)) bus ();

  keypad_emulator #(
    .BOUNCE_PERIOD  (BP),
    .BOUNCE_TOGGLES (BT),
    .HOLD_W         (HOLD_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical layout, row by row, left to right.
  int layout [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_rows(input int k, input bit closed, input logic [3:0] c);
    logic [3:0] r;
    r = 4'b1111;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (layout[ri][ci] == k && closed && c[ci] == 1'b0) r[ri] = 1'b0;
    return r;
  endfunction

  function automatic logic [3:0] pick_cols(input int mode, input logic [3:0] fix, input int i);
    logic [3:0] one;
    one = 4'b0001;
    if (mode == 1) return fix;
    if (mode == 2) return ~(one << (i % 4));
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic check_idle(input string tag);
    bus.cols = 4'($urandom_range(0, 15));
    #1;
    check_val({tag, "_rows"}, 32'(bus.rows), 32'hF);
    check_val({tag, "_busy"}, 32'(bus.busy), 32'h0);
    check_val({tag, "_done"}, 32'(bus.done), 32'h0);
  endtask

  // One press; inj_start / inj_rst give the cycle index of a stray Start or a reset, -1 for none.
  task automatic run_press(input int k, input int hold, input bit bnc, input int cmode,
                           input logic [3:0] cfix, input int inj_start, input int inj_rst);
    bit exp_c[$];
    int hh;
    int n;
    logic [3:0] cv;
    hh = (hold == 0) ? 1 : hold;
    if (bnc) for (int t = 0; t < BT * BP; t++) exp_c.push_back(((t / BP) % 2) == 0);
    for (int t = 0; t < hh; t++) exp_c.push_back(1'b1);
    if (bnc) for (int t = 0; t < BT * BP; t++) exp_c.push_back(((t / BP) % 2) == 1);
    n = exp_c.size();

    @(negedge clk);
    bus.key         = 4'(k);
    bus.hold_cycles = HOLD_W'(hold);
    bus.bounce_en   = bnc;
    bus.start       = 1'b1;
    check_idle("pre");

    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      bus.start       = (i == inj_start);
      bus.key         = (i == inj_start) ? 4'd9 : 4'($urandom_range(0, 15));
      bus.hold_cycles = HOLD_W'($urandom_range(0, 40));
      bus.bounce_en   = 1'($urandom_range(0, 1));
      cv = pick_cols(cmode, cfix, i);
      bus.cols = cv;
      #1;
      check_val("rows", 32'(bus.rows), 32'(model_rows(k, (i < n) ? exp_c[i] : 1'b0, cv)));
      check_val("busy", 32'(bus.busy), 32'h1);
      check_val("done", 32'(bus.done), (i == n) ? 32'h1 : 32'h0);
      if (i == inj_rst) begin
        rst_n = 1'b0;
        #1;
        check_val("rst_rows", 32'(bus.rows), 32'hF);
        check_val("rst_busy", 32'(bus.busy), 32'h0);
        check_val("rst_done", 32'(bus.done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.start = 1'b0;
        check_idle("post_rst");
        break;
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
    check_idle("after");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.key = 4'd0;
    bus.hold_cycles = {HOLD_W{1'b0}};
    bus.bounce_en = 1'b0;
    bus.cols = 4'b1111;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("reset");
    end
    rst_n = 1'b1;

    // Clean press with matching column, then with a non-matching column.
    run_press(5, 10, 1'b0, 1, 4'b1101, -1, -1);
    run_press(5, 10, 1'b0, 1, 4'b1110, -1, -1);

    // Every key with a walking column scan.
    for (int k = 0; k < 16; k++) run_press(k, $urandom_range(1, 6), 1'b0, 2, 4'b0000, -1, -1);

    // Boundary holds: zero and one behave alike.
    run_press(12, 0, 1'b0, 2, 4'b0000, -1, -1);
    run_press(12, 1, 1'b1, 2, 4'b0000, -1, -1);

    // Bounce on key 1, column 0 driven.
    run_press(1, 20, 1'b1, 1, 4'b1110, -1, -1);

    // Stray Start mid-hold is ignored.
    run_press(7, 15, 1'b0, 2, 4'b0000, 5, -1);

    // Reset during make bounce, then a normal press.
    run_press(2, 5, 1'b1, 2, 4'b0000, -1, 6);
    run_press(2, 5, 1'b1, 2, 4'b0000, -1, -1);

    // Random presses with idle gaps.
    for (int j = 0; j < 12; j++) begin
      run_press($urandom_range(0, 15), $urandom_range(0, 12), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), 4'($urandom_range(0, 15)), -1, -1);
      for (int g = 0; g < $urandom_range(0, 3); g++) begin
        @(negedge clk);
        check_idle("gap");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
